// File: rtl/idea_decrypt_key_gen.sv
// IDEA decryption subkey generator: expands the 128-bit key, inverts 18 subkeys
// iteratively and serves one round bundle per round_sel. Optional IDEA_INV_SELFCHECK_EN.

module idea_decrypt_key_gen #(
  parameter int NUM_ROUNDS = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [127:0] i_key,
  input  logic         i_start,
  input  logic [3:0]   i_round_sel,
  output logic [127:0] o_dk_out,
  output logic         o_busy,
  output logic         o_ready,
  output logic         o_inv_err
);

  localparam int NUM_KEYS = 6*NUM_ROUNDS + 4;
  localparam int NUM_INV  = 2*NUM_ROUNDS + 2;
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [5:0] LAST_BASE  = 6'(6*NUM_ROUNDS);
  localparam logic [5:0] TAIL_BASE  = 6'(6*NUM_ROUNDS - 2);
`ifdef IDEA_INV_SELFCHECK_EN
  localparam logic [4:0] LAST_STEP = 5'd31;
`else
  localparam logic [4:0] LAST_STEP = 5'd30;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXPAND,
    S_INV,
    S_DONE
  } state_t;

  state_t       r_state;
  state_t       w_nextState;
  logic [127:0] r_keyReg;
  logic [2:0]   r_expCnt;
  logic [4:0]   r_invIdx;
  logic [4:0]   r_step;
  logic [15:0]  r_acc;
  logic [15:0]  r_ek [0:NUM_KEYS-1];

  logic         w_accept;
  logic         w_stepLast;
  logic         w_invWrite;
  logic         w_squarePhase;
  logic [5:0]   w_invAddr;
  logic [15:0]  w_x;
  logic [15:0]  w_mulB;
  logic [15:0]  w_mulP;
  logic [15:0]  w_invData;
  logic [127:0] w_rot;

  // Multiply mod 65537 with 0 standing for 65536; uses 2^16 == -1 (mod 65537)
  function automatic logic [15:0] mulMod(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] aExt;
    logic [16:0] bExt;
    logic [32:0] prod;
    logic [15:0] lo;
    logic [16:0] hi;
    aExt = (a == 16'd0) ? 17'h10000 : {1'b0, a};
    bExt = (b == 16'd0) ? 17'h10000 : {1'b0, b};
    prod = {16'd0, aExt} * {16'd0, bExt};
    lo   = prod[15:0];
    hi   = prod[32:16];
    if ({1'b0, lo} >= hi) mulMod = 16'({1'b0, lo} - hi);
    else                  mulMod = 16'({1'b0, lo} + 17'd65537 - hi);
  endfunction

  function automatic logic [15:0] negMod(input logic [15:0] x);
    negMod = 16'd0 - x;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_accept    = i_start && (r_state == S_IDLE || r_state == S_DONE);
    w_nextState = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_accept) w_nextState = S_LOAD;
      S_LOAD:         w_nextState = S_EXPAND;
      S_EXPAND:       if (r_expCnt == 3'd6) w_nextState = S_INV;
      S_INV:          if (w_stepLast && r_invIdx == 5'(NUM_INV-1)) w_nextState = S_DONE;
      default:        w_nextState = S_IDLE;
    endcase
  end

  // Inverse order walks the schedule backwards: EK[48],EK[51],EK[42],EK[45],...
  always_comb begin
    w_rot      = {r_keyReg[102:0], r_keyReg[127:103]};
    w_stepLast = (r_step == LAST_STEP);
    w_invWrite = (r_state == S_INV) && w_stepLast;
    w_invAddr  = LAST_BASE - ({2'b00, r_invIdx[4:1]} * 6'd6) + (r_invIdx[0] ? 6'd3 : 6'd0);
    w_x        = r_ek[w_invAddr];
`ifdef IDEA_INV_SELFCHECK_EN
    w_squarePhase = r_step[0] && !w_stepLast;
    w_invData     = r_acc;
`else
    w_squarePhase = r_step[0];
    w_invData     = w_mulP;
`endif
    w_mulB = w_squarePhase ? r_acc : w_x;
    w_mulP = mulMod(r_acc, w_mulB);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_keyReg <= '0;
      r_expCnt <= '0;
      r_invIdx <= '0;
      r_step   <= '0;
      r_acc    <= '0;
    end else begin
      if (w_accept)                  r_keyReg <= i_key;
      else if (r_state == S_EXPAND)  r_keyReg <= w_rot;

      if (r_state == S_EXPAND) r_expCnt <= r_expCnt + 3'd1;
      else                     r_expCnt <= '0;

      if (r_state == S_INV) begin
        r_acc <= (r_step == 5'd0) ? w_x : w_mulP;
        if (w_stepLast) begin
          r_step   <= '0;
          r_invIdx <= r_invIdx + 5'd1;
        end else begin
          r_step <= r_step + 5'd1;
        end
      end else begin
        r_step   <= '0;
        r_invIdx <= '0;
      end
    end
  end

  // Inverses overwrite their source words in place once each operation finishes
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_KEYS; k++) r_ek[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (r_state == S_EXPAND && r_expCnt == 3'(k/8))
          r_ek[k] <= r_keyReg[127-16*(k%8) -: 16];
        else if (w_invWrite && w_invAddr == 6'(k))
          r_ek[k] <= w_invData;
      end
    end
  end

`ifdef IDEA_INV_SELFCHECK_EN
  logic r_invErr;

  always_ff @(posedge i_clk) begin
    if (i_reset)                        r_invErr <= 1'b0;
    else if (w_invWrite && w_mulP != 16'd1) r_invErr <= 1'b1;
  end

  assign o_inv_err = r_invErr;
`else
  assign o_inv_err = 1'b0;
`endif

  logic [3:0]  w_selC;
  logic [3:0]  w_tailSel;
  logic [5:0]  w_base;
  logic [5:0]  w_tailBase;
  logic        w_swap;
  logic [15:0] w_dk1, w_dk2, w_dk3, w_dk4, w_dk5, w_dk6;

  // Middle rounds swap DK2/DK3 to undo the swap inside the round function
  always_comb begin
    w_selC     = (i_round_sel > LAST_ROUND) ? 4'd0 : i_round_sel;
    w_tailSel  = (w_selC == LAST_ROUND) ? LAST_ROUND - 4'd1 : w_selC;
    w_base     = LAST_BASE - ({2'b00, w_selC} * 6'd6);
    w_tailBase = TAIL_BASE - ({2'b00, w_tailSel} * 6'd6);
    w_swap     = (w_selC != 4'd0) && (w_selC != LAST_ROUND);
    w_dk1      = r_ek[w_base];
    w_dk4      = r_ek[w_base + 6'd3];
    w_dk2      = negMod(w_swap ? r_ek[w_base + 6'd2] : r_ek[w_base + 6'd1]);
    w_dk3      = negMod(w_swap ? r_ek[w_base + 6'd1] : r_ek[w_base + 6'd2]);
    w_dk5      = (w_selC == LAST_ROUND) ? 16'd0 : r_ek[w_tailBase];
    w_dk6      = (w_selC == LAST_ROUND) ? 16'd0 : r_ek[w_tailBase + 6'd1];
    if (i_round_sel > LAST_ROUND) o_dk_out = '0;
    else o_dk_out = {w_dk1, w_dk2, w_dk3, w_dk4, w_dk5, w_dk6, 32'd0};
  end

  assign o_busy  = (r_state == S_LOAD) || (r_state == S_EXPAND) || (r_state == S_INV);
  assign o_ready = (r_state == S_DONE);

endmodule

// File: doc/idea_decrypt_key_gen.md
Name: idea_decrypt_key_gen

Overview:
- Iterative generator of the 52 IDEA decryption subkeys from a 128-bit user key.
- Feeds the round datapath so that it runs decryption rather than encryption.
- Expands the encryption key schedule, computes 18 multiplicative inverses mod 65537 and 18 additive inverses mod 65536.
- Presents one 6-subkey bundle per round on a 128-bit key bus, selected by round index.

Parameters:
- NUM_ROUNDS, 8, number of full rounds; subkey count is 6*NUM_ROUNDS+4; only 8 is supported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- key  input  128  user key [0:127], sampled on the accepted start
- start  input  1  one-cycle request; ignored while busy=1
- round_sel  input  4  decryption round index 0..8; 8 selects the output transform
- dk_out  output  128  [0:15]=DK1, [16:31]=DK2, [32:47]=DK3, [48:63]=DK4, [64:79]=DK5, [80:95]=DK6, [96:127]=0; for round_sel=8, DK5/DK6 are 0
- busy  output  1  high from the cycle after an accepted start until ready rises
- ready  output  1  level; high while the stored subkeys are valid
- inv_err  output  1  sticky self-check failure flag (see Optional Feature)

Behaviour:
- Reset state: all outputs 0; state IDLE; all subkey storage cleared to 0.
- Reset mid-operation aborts the computation and returns to the reset state.
- Arithmetic rules:
  - Modular multiply uses a 17-bit operand; a 16-bit value of 0 represents 65536.
  - A product result of 65536 is stored as 0.
  - inv(x) = x^65535 mod 65537, so inv(0)=0 and inv(1)=1.
  - Additive inverse neg(x) = (65536-x) mod 65536.
- start accepted: start=1 while busy=0, in IDLE or DONE.
  - key is captured; ready clears on the next edge; busy sets.
- States:
  - IDLE: wait for start.
  - EXPAND: 7 cycles. EK[0..7] = key words. Each cycle rotates the 128-bit register left by 25 and stores the next 8 words. Stop after EK[51].
  - INV: 18 operations, 31 cycles each: 1 load cycle (acc=x), then 15 iterations of square followed by multiply-by-x, one multiply per cycle. Operands in order: EK[48],EK[51],EK[42],EK[45],...,EK[0],EK[3].
  - DONE: busy=0, ready=1; stay until reset or a new start.
- Latency: ready rises 566 clock edges after the accept edge (1+7+558).
- Round mapping (combinational from storage), with m = 8-round_sel:
  - DK1 = inv(EK[6m]); DK4 = inv(EK[6m+3]).
  - round_sel 0 or 8: DK2 = neg(EK[6m+1]), DK3 = neg(EK[6m+2]).
  - Otherwise: DK2 = neg(EK[6m+2]), DK3 = neg(EK[6m+1]).
  - DK5 = EK[6(m-1)+4]; DK6 = EK[6(m-1)+5] (round_sel 0..7).
- round_sel > 8: dk_out = 0.
- dk_out is don't-care while ready=0.
- start while busy=1 is ignored; start in DONE recomputes from scratch.
- Same-cycle start and reset: reset wins.

Optional Feature:
- Macro: IDEA_INV_SELFCHECK_EN.
- Defined:
  - One extra cycle per inverse computes x*inv(x) mod 65537 (with the 0 -> 65536 rule).
  - A result != 1 sets inv_err; it stays set until reset.
  - Latency becomes 584 edges.
- Not defined: inv_err tied to 0; latency 566.

Test Plan:
- Reset asserted -> dk_out=0, busy=0, ready=0, inv_err=0.
- key=0x00010002000300040005000600070008, start pulse -> busy high next cycle; ready exactly 566 edges after accept (584 with macro).
  - round_sel=0 -> dk_out[0:95]=fe01_ff40_ff00_659a_c000_e001.
  - round_sel=8 -> dk_out[0:15]=inv(0x0001)=0x0001, DK2=neg(0x0002)=0xfffe, DK3=neg(0x0003)=0xfffd, DK4=inv(0x0004)=0xc001.
- key=0 -> after ready, every round_sel 0..8 gives dk_out=0 (inv(0)=0, neg(0)=0); inv_err=0.
- Second start 100 cycles into INV -> ignored; ready timing unchanged from the first start.
- Reset at cycle 300 of INV, then start with the same key -> identical dk_out and timing as a clean run.
- round_sel=9..15 after ready -> dk_out=0; with the macro, a full run on a random key leaves inv_err=0.
